// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared FSM state type and default widths for the div_seq divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int N_WIDTH_DEF = 43;
  localparam int D_WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one restoring-division step (shift in a bit, trial subtract, select)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int D_WIDTH = 18
) (
  input  logic [D_WIDTH:0] rem_i,
  input  logic             bit_i,
  input  logic [D_WIDTH:0] dvs_i,
  output logic [D_WIDTH:0] rem_o,
  output logic             q_o
);

  logic [D_WIDTH+1:0] shifted;
  logic [D_WIDTH+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};

  // No borrow out of the trial subtraction means the divisor fits.
  assign q_o   = ~diff[D_WIDTH+1];
  assign rem_o = q_o ? diff[D_WIDTH:0] : shifted[D_WIDTH:0];

endmodule : div_step

`default_nettype wire

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : sequential signed restoring divider, one quotient bit per cycle,
//           valid/ready handshakes on both sides, fixed N_WIDTH-cycle latency
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq
  import div_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [N_WIDTH-1:0] dividend_i,
  input  logic signed [D_WIDTH-1:0] divisor_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic signed [N_WIDTH-1:0] quot_o,
  output logic signed [D_WIDTH-1:0] rem_o,
  output logic                      dz_o,
  output logic                      ovf_o
);

  localparam int            CW       = $clog2(N_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  // Control and output registers (reset)
  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [N_WIDTH-1:0] quot_q, quot_d;
  logic signed [D_WIDTH-1:0] rem_q, rem_d;
  logic                      dz_q, dz_d;
  logic                      ovf_q, ovf_d;

  // Datapath working registers (no reset)
  logic [N_WIDTH-1:0]        acc_q;
  logic [D_WIDTH:0]          prem_q;
  logic [D_WIDTH:0]          dvs_q;
  logic                      qneg_q;
  logic                      rneg_q;
  logic                      dz_pend_q;
  logic                      ovf_pend_q;
  logic [D_WIDTH-1:0]        dvd_lo_q;

  logic                      accept;
  logic [N_WIDTH-1:0]        dvd_mag;
  logic [D_WIDTH:0]          dvs_ext;
  logic [D_WIDTH:0]          dvs_mag;
  logic                      is_dz;
  logic                      is_ovf;
  logic [D_WIDTH:0]          step_rem;
  logic                      step_q;
  logic [N_WIDTH-1:0]        q_mag;
  logic [D_WIDTH-1:0]        r_mag;

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign accept  = valid_i & ready_o;

  // Divisor magnitude needs one extra bit so the most negative value negates cleanly.
  assign dvd_mag = dividend_i[N_WIDTH-1] ? $unsigned(-dividend_i) : $unsigned(dividend_i);
  assign dvs_ext = {divisor_i[D_WIDTH-1], divisor_i};
  assign dvs_mag = dvs_ext[D_WIDTH] ? ({(D_WIDTH+1){1'b0}} - dvs_ext) : dvs_ext;

  assign is_dz  = (divisor_i == '0);
  assign is_ovf = (dividend_i == {1'b1, {(N_WIDTH-1){1'b0}}}) && (divisor_i == '1);

  div_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .rem_i (prem_q),
    .bit_i (acc_q[N_WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign q_mag = {acc_q[N_WIDTH-2:0], step_q};
  assign r_mag = step_rem[D_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = ST_CALC;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          dz_d    = dz_pend_q;
          ovf_d   = ovf_pend_q;
          if (dz_pend_q) begin
            quot_d = '1;
            rem_d  = dvd_lo_q;
          end else begin
            quot_d = qneg_q ? -q_mag : q_mag;
            rem_d  = rneg_q ? -r_mag : r_mag;
          end
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operands are captured once at accept; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      acc_q      <= dvd_mag;
      prem_q     <= '0;
      dvs_q      <= dvs_mag;
      qneg_q     <= dividend_i[N_WIDTH-1] ^ divisor_i[D_WIDTH-1];
      rneg_q     <= dividend_i[N_WIDTH-1];
      dz_pend_q  <= is_dz;
      ovf_pend_q <= is_ovf;
      dvd_lo_q   <= dividend_i[D_WIDTH-1:0];
    end else if (state_q == ST_CALC) begin
      acc_q  <= q_mag;
      prem_q <= step_rem;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;
  assign ovf_o  = ovf_q;

endmodule : div_seq

`default_nettype wire

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq : directed-vector and reference-model bench for div_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_seq;

  localparam int N = 43;
  localparam int D = 18;
  localparam int LAT = 43;
  localparam longint MIN_N = -(64'sd1 <<< (N-1));
  localparam longint MAX_N = (64'sd1 <<< (N-1)) - 1;
  localparam longint MIN_D = -(64'sd1 <<< (D-1));
  localparam longint MAX_D = (64'sd1 <<< (D-1)) - 1;

  typedef struct {
    longint a;
    longint b;
    longint q;
    longint r;
    logic   dz;
    logic   ovf;
  } vec_t;

  logic                clk = 1'b0;
  logic                arst_n;
  logic                valid_i, ready_i;
  logic                ready_o, valid_o, dz_o, ovf_o;
  logic signed [N-1:0] dividend_i, quot_o;
  logic signed [D-1:0] divisor_i, rem_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_seq #(
    .N_WIDTH (N),
    .D_WIDTH (D)
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .dz_o       (dz_o),
    .ovf_o      (ovf_o)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input longint a, input longint b,
                       output longint q, output longint r,
                       output logic dz, output logic ovf, output int lat);
    int n;
    n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_accept", ready_o, 1);
    valid_i    = 1'b1;
    dividend_i = N'(a);
    divisor_i  = D'(b);
    @(posedge clk); #1;
    valid_i    = 1'b0;
    dividend_i = N'({$urandom, $urandom});
    divisor_i  = D'($urandom);
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = quot_o;
    r   = rem_o;
    dz  = dz_o;
    ovf = ovf_o;
    if (ready_i) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic void ref_div(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output logic dz, output logic ovf);
    logic signed [N-1:0] qt;
    logic signed [D-1:0] rt;
    if (b == 0) begin
      qt  = '1;
      rt  = a[D-1:0];
      dz  = 1'b1;
      ovf = 1'b0;
    end else begin
      qt  = N'(a / b);
      rt  = D'(a % b);
      dz  = 1'b0;
      ovf = (a == MIN_N) && (b == -1);
    end
    q = qt;
    r = rt;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[10];
    longint q, r, eq, er;
    logic   dz, ovf, edz, eovf;
    int     lat, seen;
    logic signed [N-1:0] ta;
    logic signed [D-1:0] tb;
    longint a, b;

    vecs[0] = '{a: 100,   b: 7,     q: 14,       r: 2,   dz: 0, ovf: 0};
    vecs[1] = '{a: -100,  b: 7,     q: -14,      r: -2,  dz: 0, ovf: 0};
    vecs[2] = '{a: 100,   b: -7,    q: -14,      r: 2,   dz: 0, ovf: 0};
    vecs[3] = '{a: -100,  b: -7,    q: 14,       r: -2,  dz: 0, ovf: 0};
    vecs[4] = '{a: 55,    b: 0,     q: -1,       r: 55,  dz: 1, ovf: 0};
    vecs[5] = '{a: MIN_N, b: -1,    q: MIN_N,    r: 0,   dz: 0, ovf: 1};
    vecs[6] = '{a: 123,   b: MIN_D, q: 0,        r: 123, dz: 0, ovf: 0};
    vecs[7] = '{a: MAX_N, b: 1,     q: MAX_N,    r: 0,   dz: 0, ovf: 0};
    vecs[8] = '{a: MIN_N, b: MIN_D, q: 33554432, r: 0,   dz: 0, ovf: 0};
    vecs[9] = '{a: MIN_N, b: 0,     q: -1,       r: 0,   dz: 1, ovf: 0};

    arst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_quot", quot_o, 0);
    chk("rst_rem", rem_o, 0);
    chk("rst_flags", {dz_o, ovf_o}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;

    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, dz, ovf, lat);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure: result must hold and new operands must be refused.
    ready_i = 1'b0;
    do_op(100, 7, q, r, dz, ovf, lat);
    chk("bp_quot", q, 14);
    chk("bp_latency", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; dividend_i = 999; divisor_i = 5;
      @(posedge clk); #1;
      chk("bp_valid_hold", valid_o, 1);
      chk("bp_ready_low", ready_o, 0);
      chk("bp_quot_hold", quot_o, 14);
      chk("bp_rem_hold", rem_o, 2);
      chk("bp_flags_hold", {dz_o, ovf_o}, 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", valid_o, 0);
    chk("bp_release_ready", ready_o, 1);

    // Reset in the middle of a calculation.
    valid_i = 1'b1; dividend_i = 100; divisor_i = 7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("mid_busy", ready_o, 0);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_quot", quot_o, 0);
    chk("mid_rst_rem", rem_o, 0);
    chk("mid_rst_flags", {dz_o, ovf_o}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("mid_no_valid_after", seen, 0);
    do_op(1000, 3, q, r, dz, ovf, lat);
    chk("post_rst_quot", q, 333);
    chk("post_rst_rem", r, 1);
    chk("post_rst_latency", lat, LAT);

    // Random back-to-back transactions against the reference model.
    ready_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0: a = MIN_N;
        1: a = MAX_N;
        default: begin
          ta = N'({$urandom, $urandom});
          ta = ta >>> $urandom_range(0, N-1);
          a  = ta;
        end
      endcase
      case ($urandom_range(0, 11))
        0: b = MIN_D;
        1: b = MAX_D;
        2: b = 0;
        3: b = -1;
        default: begin
          tb = D'($urandom);
          tb = tb >>> $urandom_range(0, D-1);
          b  = tb;
        end
      endcase
      ref_div(a, b, eq, er, edz, eovf);
      do_op(a, b, q, r, dz, ovf, lat);
      chk($sformatf("rnd%0d_quot a=%0d b=%0d", i, a, b), q, eq);
      chk($sformatf("rnd%0d_rem a=%0d b=%0d", i, a, b), r, er);
      chk($sformatf("rnd%0d_dz", i), dz, edz);
      chk($sformatf("rnd%0d_ovf", i), ovf, eovf);
      chk($sformatf("rnd%0d_latency", i), lat, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_div_seq

`default_nettype wire
